adder_sequencer: RTL
====================

// Module: adder_sequencer
// PURPOSE
//  Sequences the shared 8+16-bit Adder to accumulate a run of byte operands.
//  Each run is seeded with init_value, accepts length bytes over a
//  valid/ready handshake and feeds each byte plus the running total to the
//  Adder. It registers each result, then reports the 16-bit sum and a sticky
//  wrap flag. Sits between a byte-stream source and the combinational Adder.
// PARAMETERS
//  COUNT_W  8  width of length and op_count; max run = 2**COUNT_W-1 operands
// PORTS
//  clk            in   1        rising-edge clock, single clock domain
//  reset_n        in   1        asynchronous, active-low reset
//  start          in   1        begin a run; sampled only in IDLE
//  length         in   COUNT_W  operand count for the run, latched on start
//  init_value     in   16       accumulator seed, latched on start
//  op_valid       in   1        op_data valid
//  op_data        in   8        byte operand
//  op_ready       out  1        sequencer accepts op_data this cycle
//  adder_operand  out  8        to Adder.new_operand (= op_data)
//  adder_current  out  16       to Adder.current_value (= accumulator)
//  adder_result   in   16       from Adder.output_value
//  busy           out  1        run in progress (state != IDLE)
//  done           out  1        one-cycle pulse, run complete
//  sum            out  16       accumulator; final value valid when done=1
//  wrap           out  1        sticky: some add in this run wrapped past 0xFFFF
//  op_count       out  COUNT_W  operands consumed in the current run
// BEHAVIOUR
//  Reset: state=IDLE; sum, wrap, op_count, remaining=0; op_ready, busy, done=0.
//   Reset is asynchronous and may be asserted at any point; a run in
//   progress is aborted with no done pulse.
//  FSM states: IDLE, ACCUM, DONE.
//   IDLE: start=1 -> latch acc<=init_value, remaining<=length, op_count<=0,
//    wrap<=0. Next state is ACCUM if length!=0, else DONE.
//   ACCUM: op_ready=1. Handshake = op_valid & op_ready. On handshake:
//    acc<=adder_result, op_count++, remaining--, wrap|=(adder_result<acc).
//    A handshake with remaining==1 moves to DONE. No handshake holds state.
//   DONE: done=1 for exactly one cycle, then IDLE. start is ignored.
//  start in ACCUM/DONE is ignored; it is not queued.
//  Arithmetic: op_data zero-extended, mod-2^16 add (done by the Adder).
//   The sequencer only registers the result and detects unsigned wrap.
//  Timing: start at edge k -> busy=1 after k. Last handshake at edge j ->
//   done=1 and final sum visible in cycle j..j+1. busy=0 after j+1.
//   Throughput is 1 operand/cycle.
//  Outputs: adder_operand=op_data and adder_current=sum, combinational.
//   sum, wrap and op_count hold after DONE until the next accepted start.
//  op_ready=0 outside ACCUM; op_data is never consumed in IDLE/DONE.
// TESTING
//  1 reset_n=0 mid-clock -> all outputs 0 immediately, state IDLE.
//  2 start len=3 init=0x0000, ops 01,42,FF back-to-back -> done on cycle
//    after 3rd handshake, sum=0x0142, wrap=0, op_count=3.
//  3 start len=1 init=0xFE01, op FF -> sum=0xFF00, wrap=0.
//    (Checks carry propagation from 8 bits into 16.)
//  4 start len=2 init=0xFFF0, ops 10,05 -> sum=0x0005, wrap=1 (sticky).
//  5 start len=0 init=0x1234 -> done one cycle after start, sum=0x1234,
//    op_ready never high. Then start len=2 with op_valid gaps -> op_ready
//    held, done only after 2nd handshake; start pulsed during ACCUM ignored.
//  6 len=3 run, reset_n low after 1st operand -> no done, outputs 0; a new
//    start len=1 init=0x4200 op 42 -> sum=0x4242.

Source files
------------

// File: rtl/adder_sequencer_if.sv
// Byte-operand stream between a byte source (master) and adder_sequencer (slave).
interface adder_sequencer_if;
  logic       op_valid;
  logic [7:0] op_data;
  logic       op_ready;

  modport master (output op_valid, output op_data, input op_ready);
  modport slave  (input op_valid, input op_data, output op_ready);
endinterface

// File: rtl/adder_sequencer.sv
// Drives an external 8+16-bit combinational Adder to accumulate a run of byte
// operands, registering each result and flagging any unsigned wrap in the run.
module adder_sequencer #(
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [COUNT_W-1:0] length,
  input  logic [15:0]        init_value,
  adder_sequencer_if.slave   op_if,
  output logic [7:0]         adder_operand,
  output logic [15:0]        adder_current,
  input  logic [15:0]        adder_result,
  output logic               busy,
  output logic               done,
  output logic [15:0]        sum,
  output logic               wrap,
  output logic [COUNT_W-1:0] op_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [15:0]        sum_q, sum_d;
  logic               wrap_q, wrap_d;
  logic [COUNT_W-1:0] op_count_q, op_count_d;
  logic [COUNT_W-1:0] remaining_q, remaining_d;
  logic               op_ready_q, op_ready_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               handshake;

  assign handshake = op_if.op_valid & op_ready_q;

  always_comb begin
    state_d     = state_q;
    sum_d       = sum_q;
    wrap_d      = wrap_q;
    op_count_d  = op_count_q;
    remaining_d = remaining_q;
    op_ready_d  = op_ready_q;
    busy_d      = busy_q;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          sum_d       = init_value;
          remaining_d = length;
          op_count_d  = '0;
          wrap_d      = 1'b0;
          busy_d      = 1'b1;
          if (length != '0) begin
            state_d    = ACCUM;
            op_ready_d = 1'b1;
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end

      ACCUM: begin
        if (handshake) begin
          sum_d       = adder_result;
          op_count_d  = op_count_q + COUNT_W'(1);
          remaining_d = remaining_q - COUNT_W'(1);
          // The addend is at most 0xFF, so a smaller result means the add wrapped.
          wrap_d      = wrap_q | (adder_result < sum_q);
          if (remaining_q == COUNT_W'(1)) begin
            state_d    = DONE;
            op_ready_d = 1'b0;
            done_d     = 1'b1;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d    = IDLE;
        op_ready_d = 1'b0;
        busy_d     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      sum_q       <= '0;
      wrap_q      <= 1'b0;
      op_count_q  <= '0;
      remaining_q <= '0;
      op_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sum_q       <= sum_d;
      wrap_q      <= wrap_d;
      op_count_q  <= op_count_d;
      remaining_q <= remaining_d;
      op_ready_q  <= op_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign op_if.op_ready = op_ready_q;
  assign adder_operand  = op_if.op_data;
  assign adder_current  = sum_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign sum            = sum_q;
  assign wrap           = wrap_q;
  assign op_count       = op_count_q;

endmodule
